// File: rtl/stock_pkg.sv
// Shared types and constants for the stock price receive path: price/byte
// widths, output FSM states and a saturating sample-counter helper.
package stock_pkg;

  localparam int PRICE_W         = 32;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_PRICE = 4;
  localparam int BYTE_CNT_W      = $clog2(BYTES_PER_PRICE);
  localparam int SAMPLE_W        = 16;

  typedef logic [PRICE_W-1:0] price_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } rx_state_t;

  function automatic logic [SAMPLE_W-1:0] sat_inc(input logic [SAMPLE_W-1:0] v);
    return (v == {SAMPLE_W{1'b1}}) ? v : v + SAMPLE_W'(1);
  endfunction

endpackage

// File: rtl/price_fifo.sv
// Synchronous price FIFO. Pointers carry an extra wrap bit so full and empty
// are distinguishable; a push into a full FIFO is accepted when a pop shares the edge.
module price_fifo
  import stock_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  price_t                   din_i,
  output price_t                   dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  price_t         mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           full_q, empty_q;
  logic           do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Status flags are registered from the next pointers: they describe the
  // occupancy after the edge, with no same-cycle bypass.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty_q  <= (wr_ptr_d == rd_ptr_d);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/stock_price_rx.sv
// Feeder for the averaging stage: assembles MSB-first price bytes into words,
// buffers them, and issues them one at a time with a paced data_ready strobe.
module stock_price_rx
  import stock_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_GAP    = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [BYTE_W-1:0]   byte_in,
  input  logic                byte_valid,
  input  logic                frame_clear,
  input  logic                consumer_ready,
  output logic [PRICE_W-1:0]  stock_price,
  output logic                data_ready,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overrun,
  output logic [SAMPLE_W-1:0] sample_count
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W  = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 2) ? MIN_GAP - 3 : 0);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_PRICE - 1);

  // ---------------- byte assembler ----------------
  // Only the three leading bytes need storing; the fourth arrives on the push edge.
  logic [BYTE_CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [PRICE_W-BYTE_W-1:0]   shift_q, shift_d;
  logic                        push_req;
  price_t                      push_word;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    push_req   = 1'b0;
    push_word  = {shift_q, byte_in};
    if (frame_clear) begin
      byte_cnt_d = '0;
      shift_d    = '0;
    end else if (byte_valid) begin
      shift_d = push_word[PRICE_W-BYTE_W-1:0];
      if (byte_cnt_q == LAST_BYTE) begin
        push_req   = 1'b1;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
      end
    end
  end

  // n_rst is active-high and synchronous despite its name.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // ---------------- price FIFO ----------------
  price_t             fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               pop_req;

  price_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (n_rst),
    .push_i  (push_req),
    .pop_i   (pop_req),
    .din_i   (push_word),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------- output FSM ----------------
  rx_state_t          state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // IDLE always costs one cycle, so GAP lasts MIN_GAP-2 cycles to make
  // consecutive strobes exactly MIN_GAP apart; MIN_GAP=2 skips GAP entirely.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = '0;
    unique case (state_q)
      IDLE:  if ((fifo_count != '0) && consumer_ready) state_d = ISSUE;
      ISSUE: state_d = (MIN_GAP > 2) ? GAP : IDLE;
      GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- registered outputs ----------------
  price_t              stock_price_q, stock_price_d;
  logic                data_ready_q, data_ready_d;
  logic                overrun_q, overrun_d;
  logic [SAMPLE_W-1:0] sample_count_q, sample_count_d;

  always_comb begin
    pop_req        = (state_q == ISSUE);
    data_ready_d   = pop_req;
    stock_price_d  = stock_price_q;
    sample_count_d = sample_count_q;
    if (pop_req) begin
      stock_price_d  = fifo_head;
      sample_count_d = sat_inc(sample_count_q);
    end
    // A completed word is lost only if the FIFO is full and nothing leaves this edge.
    overrun_d = overrun_q || (push_req && fifo_full && !(pop_req && !fifo_empty));
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      stock_price_q  <= '0;
      data_ready_q   <= 1'b0;
      overrun_q      <= 1'b0;
      sample_count_q <= '0;
    end else begin
      stock_price_q  <= stock_price_d;
      data_ready_q   <= data_ready_d;
      overrun_q      <= overrun_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign stock_price  = stock_price_q;
  assign data_ready   = data_ready_q;
  assign overrun      = overrun_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_stock_price_rx.sv
// Self-checking bench for stock_price_rx: table-driven single prices, directed
// corner sequences, and random traffic checked against a queue-based model.
module tb_stock_price_rx;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [7:0]  byte_in;
  logic        byte_valid, frame_clear, consumer_ready;
  logic [31:0] stock_price;
  logic        data_ready, fifo_full, fifo_empty, overrun;
  logic [15:0] sample_count;

  stock_price_rx #(
    .FIFO_DEPTH (DEPTH),
    .MIN_GAP    (GAP)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .frame_clear    (frame_clear),
    .consumer_ready (consumer_ready),
    .stock_price    (stock_price),
    .data_ready     (data_ready),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .overrun        (overrun),
    .sample_count   (sample_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Timestamp view: a strobe is decided at edge t when the previous strobe was
  // at least GAP-1 edges ago, a word was buffered before t and consumer_ready
  // is high; the word is then delivered at edge t+1.
  logic [31:0] m_q[$];
  int          m_cnt     = 0;
  logic [31:0] m_word    = '0;
  logic [31:0] m_price   = '0;
  logic        m_dr      = 1'b0;
  logic        m_over    = 1'b0;
  logic        m_pending = 1'b0;
  int          m_samples = 0;
  longint      m_edge    = 0;
  longint      m_last    = -100;
  bit          chk_en    = 1'b0;

  task automatic model_step();
    bit decide;
    m_edge++;
    if (n_rst) begin
      m_q.delete();
      m_cnt = 0; m_word = '0; m_price = '0; m_dr = 1'b0; m_over = 1'b0;
      m_samples = 0; m_pending = 1'b0; m_last = -100;
    end else begin
      decide = !m_pending && (m_edge >= m_last + GAP - 1) && (m_q.size() != 0) && consumer_ready;
      m_dr = m_pending;
      if (m_pending) begin
        m_price = m_q.pop_front();
        if (m_samples < 65535) m_samples++;
        m_last = m_edge;
      end
      if (frame_clear) begin
        m_cnt = 0; m_word = '0;
      end else if (byte_valid) begin
        m_word = {m_word[23:0], byte_in};
        if (m_cnt == 3) begin
          m_cnt = 0;
          if (m_q.size() < DEPTH) m_q.push_back(m_word);
          else m_over = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      m_pending = decide;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_stock_price",  stock_price, m_price);
      check("model_data_ready",   32'(data_ready), 32'(m_dr));
      check("model_fifo_full",    32'(fifo_full), 32'(m_q.size() == DEPTH));
      check("model_fifo_empty",   32'(fifo_empty), 32'(m_q.size() == 0));
      check("model_overrun",      32'(overrun), 32'(m_over));
      check("model_sample_count", 32'(sample_count), 32'(m_samples));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge: drive inputs, then advance to the next falling edge.
  task automatic cyc(input logic bv, input logic [7:0] b, input logic fc,
                     input logic cr, input logic rst);
    byte_valid = bv; byte_in = b; frame_clear = fc; consumer_ready = cr; n_rst = rst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n, input logic cr);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, cr, 1'b0);
  endtask

  task automatic send_price(input logic [31:0] p, input logic cr);
    for (int i = 3; i >= 0; i--) cyc(1'b1, p[8*i +: 8], 1'b0, cr, 1'b0);
  endtask

  task automatic wait_pulse(input string tag, input int budget, output int waited);
    waited = 0;
    while (!data_ready && waited < budget) begin
      idle(1, 1'b1);
      waited++;
    end
    check({tag, "_pulse_seen"}, 32'(data_ready), 32'd1);
  endtask

  logic [31:0] exp_q[$];

  task automatic drain(input string tag, input int budget);
    int n = 0;
    int last = 0;
    for (int c = 0; c < budget; c++) begin
      idle(1, 1'b1);
      if (data_ready) begin
        if (n < exp_q.size()) check({tag, "_order"}, stock_price, exp_q[n]);
        if (n > 0) check({tag, "_spacing"}, 32'(c - last), 32'(GAP));
        last = c;
        n++;
      end
    end
    check({tag, "_pulse_count"}, 32'(n), 32'(exp_q.size()));
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_price;
    logic [15:0] exp_count;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    logic [31:0] sent [10];
    logic [31:0] newp;
    int          w;

    vecs[0] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h12345678, 16'd1};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 16'd2};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 16'd3};
    vecs[3] = '{8'h80, 8'h00, 8'h00, 8'h01, 32'h80000001, 16'd4};
    vecs[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF, 16'd5};

    byte_valid = 1'b0; byte_in = 8'h00; frame_clear = 1'b0;
    consumer_ready = 1'b0; n_rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    check("rst_stock_price",  stock_price, 32'h0);
    check("rst_data_ready",   32'(data_ready), 32'd0);
    check("rst_fifo_empty",   32'(fifo_empty), 32'd1);
    check("rst_fifo_full",    32'(fifo_full), 32'd0);
    check("rst_overrun",      32'(overrun), 32'd0);
    check("rst_sample_count", 32'(sample_count), 32'd0);

    // Single prices with an idle FIFO: value, count and edge-N+2 latency.
    for (int i = 0; i < 5; i++) begin
      idle(6, 1'b1);
      cyc(1'b1, vecs[i].b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, vecs[i].b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, vecs[i].b2, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, vecs[i].b3, 1'b0, 1'b1, 1'b0);
      check("vec_no_early_pulse", 32'(data_ready), 32'd0);
      wait_pulse("vec", 10, w);
      check("vec_latency", 32'(w), 32'd2);
      check("vec_price", stock_price, vecs[i].exp_price);
      check("vec_sample_count", 32'(sample_count), 32'(vecs[i].exp_count));
      idle(1, 1'b1);
      check("vec_strobe_one_cycle", 32'(data_ready), 32'd0);
      check("vec_price_held", stock_price, vecs[i].exp_price);
    end

    // frame_clear discards a partial word and wins over a coincident byte.
    do_reset();
    cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
    send_price(32'h01020304, 1'b1);
    wait_pulse("clr", 10, w);
    check("clr_price", stock_price, 32'h01020304);
    idle(10, 1'b1);
    check("clr_single_sample", 32'(sample_count), 32'd1);
    check("clr_fifo_empty", 32'(fifo_empty), 32'd1);

    // Overflow: ten prices with the consumer stalled, then drain.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sent[i] = $urandom;
      send_price(sent[i], 1'b0);
      if (i == 6) check("ovf_not_full_at_7", 32'(fifo_full), 32'd0);
      if (i == 7) begin
        check("ovf_full_at_8", 32'(fifo_full), 32'd1);
        check("ovf_no_overrun_at_8", 32'(overrun), 32'd0);
      end
      if (i >= 8) check("ovf_overrun_set", 32'(overrun), 32'd1);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(sent[i]);
    drain("ovf", 60);
    check("ovf_overrun_sticky", 32'(overrun), 32'd1);
    check("ovf_empty_after", 32'(fifo_empty), 32'd1);

    // Reset mid-word with two prices buffered and overrun still set.
    send_price(32'hCAFE0001, 1'b0);
    send_price(32'hCAFE0002, 1'b0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("mid_rst_stock_price",  stock_price, 32'h0);
    check("mid_rst_data_ready",   32'(data_ready), 32'd0);
    check("mid_rst_fifo_empty",   32'(fifo_empty), 32'd1);
    check("mid_rst_fifo_full",    32'(fifo_full), 32'd0);
    check("mid_rst_overrun",      32'(overrun), 32'd0);
    check("mid_rst_sample_count", 32'(sample_count), 32'd0);
    send_price(32'h0BADF00D, 1'b1);
    wait_pulse("mid_rst", 10, w);
    check("mid_rst_new_price", stock_price, 32'h0BADF00D);
    check("mid_rst_new_count", 32'(sample_count), 32'd1);
    idle(10, 1'b1);
    check("mid_rst_no_stale", 32'(sample_count), 32'd1);

    // Three buffered prices delivered exactly GAP cycles apart.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      newp = $urandom;
      exp_q.push_back(newp);
      send_price(newp, 1'b0);
    end
    drain("pace", 30);

    // Full FIFO: the fourth byte lands on the issue edge and is accepted.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      sent[i] = $urandom;
      send_price(sent[i], 1'b0);
    end
    newp = 32'hA5C3_7E19;
    cyc(1'b1, newp[31:24], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, newp[23:16], 1'b0, 1'b0, 1'b0);
    cyc(1'b1, newp[15:8],  1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00,       1'b0, 1'b1, 1'b0);
    cyc(1'b1, newp[7:0],   1'b0, 1'b1, 1'b0);
    check("edge_pulse", 32'(data_ready), 32'd1);
    check("edge_first_price", stock_price, sent[0]);
    check("edge_no_overrun", 32'(overrun), 32'd0);
    check("edge_still_full", 32'(fifo_full), 32'd1);
    for (int i = 1; i < 8; i++) exp_q.push_back(sent[i]);
    exp_q.push_back(newp);
    drain("edge", 60);
    check("edge_no_overrun_end", 32'(overrun), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 4),
          ($urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 80 : 15)),
          ($urandom_range(0, 599) == 0));
    end
    idle(40, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
